// File: rtl/snapshot_regfile.sv
// Live register bank with a shadow snapshot bank, random read port and a
// valid/ready dump stream. Define SNAPSHOT_REGFILE_SNAP_CNT_EN to enable the snapshot counter.
module snapshot_regfile #(
    parameter int REG_NUM   = 8,
    parameter int REG_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         wr_en_i,
    input  logic [REG_NUM-1:0]           wr_mask_i,
    input  logic [REG_NUM*REG_WIDTH-1:0] wr_data_i,
    input  logic                         snap_i,
    input  logic [$clog2(REG_NUM)-1:0]   rd_addr_i,
    output logic [REG_WIDTH-1:0]         rd_data_o,
    input  logic                         dump_start_i,
    output logic                         st_valid_o,
    input  logic                         st_ready_i,
    output logic [REG_WIDTH-1:0]         st_data_o,
    output logic                         st_last_o,
    output logic                         dump_busy_o,
    output logic                         snap_pend_o,
    output logic [15:0]                  snap_cnt_o
);

    localparam int AW = $clog2(REG_NUM);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [AW-1:0]        idx, idx_nxt;
    logic                 pend, pend_nxt;
    logic                 snap_apply;
    logic                 last;
    logic [REG_WIDTH-1:0] live   [REG_NUM];
    logic [REG_WIDTH-1:0] shadow [REG_NUM];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pend_nxt    = pend;
        snap_apply  = 1'b0;
        last        = 1'b0;
        st_valid_o  = 1'b0;
        st_data_o   = '0;
        st_last_o   = 1'b0;
        dump_busy_o = 1'b0;
        case (state)
            IDLE: begin
                snap_apply = snap_i;
                if (dump_start_i) begin
                    state_nxt = STREAM;
                    idx_nxt   = '0;
                end
            end
            STREAM: begin
                last        = (idx == AW'(REG_NUM - 1));
                st_valid_o  = 1'b1;
                dump_busy_o = 1'b1;
                st_data_o   = shadow[idx];
                st_last_o   = last;
                if (st_ready_i && last) begin
                    // Deferred and same-edge requests merge into one snapshot here.
                    state_nxt  = IDLE;
                    idx_nxt    = '0;
                    snap_apply = pend | snap_i;
                    pend_nxt   = 1'b0;
                end else begin
                    if (st_ready_i) begin
                        idx_nxt = idx + AW'(1);
                    end
                    if (snap_i) begin
                        pend_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            idx   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            pend  <= pend_nxt;
        end
    end

    // NOTE: both banks must read 0 after reset, so they are built from resettable flops, not RAM.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < REG_NUM; i++) begin
                live[i]   <= '0;
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (wr_en_i && wr_mask_i[i]) begin
                    live[i] <= wr_data_i[i*REG_WIDTH +: REG_WIDTH];
                end
                // Shadow takes the pre-edge live value; a same-edge write lands next snapshot.
                if (snap_apply) begin
                    shadow[i] <= live[i];
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        if (int'(rd_addr_i) < REG_NUM) begin
            rd_data_o = shadow[rd_addr_i];
        end
    end

    assign snap_pend_o = pend;

`ifdef SNAPSHOT_REGFILE_SNAP_CNT_EN
    logic [15:0] snap_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            snap_cnt <= '0;
        end else if (snap_apply) begin
            snap_cnt <= snap_cnt + 16'd1;
        end
    end

    assign snap_cnt_o = snap_cnt;
`else
    assign snap_cnt_o = '0;
`endif

endmodule

// File: tb/tb_snapshot_regfile.sv
// Directed self-checking bench for snapshot_regfile (REG_NUM=8, REG_WIDTH=8).
// Expected counter values follow SNAPSHOT_REGFILE_SNAP_CNT_EN when it is defined.
module tb_snapshot_regfile;

    localparam int N = 8;
    localparam int W = 8;
`ifdef SNAPSHOT_REGFILE_SNAP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           wr_en;
    logic [N-1:0]   wr_mask;
    logic [N*W-1:0] wr_data;
    logic           snap;
    logic [2:0]     rd_addr;
    logic [W-1:0]   rd_data;
    logic           dump_start;
    logic           st_valid;
    logic           st_ready;
    logic [W-1:0]   st_data;
    logic           st_last;
    logic           dump_busy;
    logic           snap_pend;
    logic [15:0]    snap_cnt;

    int total = 0;
    int bad   = 0;
    int snaps = 0;
    int beats;

    always #5 clk = ~clk;

    snapshot_regfile #(.REG_NUM(N), .REG_WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .wr_en_i      (wr_en),
        .wr_mask_i    (wr_mask),
        .wr_data_i    (wr_data),
        .snap_i       (snap),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .dump_start_i (dump_start),
        .st_valid_o   (st_valid),
        .st_ready_i   (st_ready),
        .st_data_o    (st_data),
        .st_last_o    (st_last),
        .dump_busy_o  (dump_busy),
        .snap_pend_o  (snap_pend),
        .snap_cnt_o   (snap_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
        return CNT_EN ? snaps[15:0] : 16'h0000;
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic read_chk(input string tag, input int addr, input logic [7:0] exp);
        rd_addr = 3'(addr);
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        snaps = 0;
    endtask

    task automatic write_live(input logic [7:0] mask, input logic [63:0] data);
        wr_en   = 1'b1;
        wr_mask = mask;
        wr_data = data;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_mask = '0; wr_data = '0; snap = 1'b0;
        rd_addr = '0; dump_start = 1'b0; st_ready = 1'b0;
        #2;
        check("rst_rd_data", rd_data, 0);
        check("rst_valid", st_valid, 0);
        check("rst_last", st_last, 0);
        check("rst_st_data", st_data, 0);
        check("rst_busy", dump_busy, 0);
        check("rst_pend", snap_pend, 0);
        check("rst_cnt", snap_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Masked write: mask 0x05 touches registers 0 and 2 only.
        write_live(8'hFF, 64'h0706050403020100);
        write_live(8'h05, 64'hFFFFFFFFFFFFFFFF);
        snap = 1'b1;
        step();
        snap = 1'b0;
        snaps++;
        read_chk("mask_r0", 0, 8'hFF);
        read_chk("mask_r1", 1, 8'h01);
        read_chk("mask_r2", 2, 8'hFF);
        read_chk("mask_r3", 3, 8'h03);
        read_chk("mask_r7", 7, 8'h07);
        check("mask_cnt", snap_cnt, exp_cnt());

        // Same-edge write and snapshot: the snapshot sees the old live value.
        do_reset();
        wr_en = 1'b1; wr_mask = 8'hFF; wr_data = {8{8'h11}}; snap = 1'b1;
        step();
        wr_en = 1'b0; snap = 1'b0;
        snaps++;
        read_chk("same_r0", 0, 8'h00);
        read_chk("same_r5", 5, 8'h00);
        snap = 1'b1;
        step();
        snap = 1'b0;
        snaps++;
        read_chk("same2_r0", 0, 8'h11);
        read_chk("same2_r7", 7, 8'h11);
        check("same_cnt", snap_cnt, exp_cnt());

        // Backpressure with ready pattern 1,0,0; dump_start mid-stream is ignored.
        write_live(8'hFF, 64'h0706050403020100);
        snap = 1'b1;
        step();
        snap = 1'b0;
        snaps++;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        beats = 0;
        for (int c = 0; c < 40 && beats < 8; c++) begin
            check("bp_valid", st_valid, 1);
            check("bp_busy", dump_busy, 1);
            check("bp_data", st_data, 64'(beats));
            check("bp_last", st_last, 64'(beats == 7));
            st_ready   = (c % 3 == 0);
            dump_start = (beats == 2);
            step();
            if (st_ready) beats++;
        end
        st_ready = 1'b0; dump_start = 1'b0;
        check("bp_beats", beats, 8);
        check("bp_busy_end", dump_busy, 0);
        check("bp_valid_end", st_valid, 0);

        // Deferred snapshot: two requests at beats 3 and 4 merge into one.
        write_live(8'hFF, {8{8'hAA}});
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        rd_addr = 3'd3;
        for (int b = 0; b < 8; b++) begin
            #1;
            check("def_data", st_data, 64'(b));
            check("def_pend", snap_pend, 64'(b >= 4));
            check("def_shadow", rd_data, 8'h03);
            st_ready = 1'b1;
            snap     = (b == 3 || b == 4);
            step();
        end
        st_ready = 1'b0; snap = 1'b0;
        snaps++;
        check("def_busy_end", dump_busy, 0);
        check("def_pend_end", snap_pend, 0);
        read_chk("def_r0", 0, 8'hAA);
        read_chk("def_r7", 7, 8'hAA);
        check("def_cnt", snap_cnt, exp_cnt());

        // Reset mid-stream with a deferred snapshot pending.
        write_live(8'hFF, {8{8'h55}});
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        st_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            snap = (b == 2);
            step();
        end
        snap = 1'b0;
        check("mid_pend", snap_pend, 1);
        check("mid_data", st_data, 8'hAA);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", st_valid, 0);
        check("mid_rst_busy", dump_busy, 0);
        check("mid_rst_last", st_last, 0);
        check("mid_rst_data", st_data, 0);
        check("mid_rst_pend", snap_pend, 0);
        check("mid_rst_cnt", snap_cnt, 0);
        for (int a = 0; a < N; a++) read_chk("mid_rst_rd", a, 8'h00);
        st_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        snaps = 0;
        check("mid_post_busy", dump_busy, 0);
        check("mid_post_pend", snap_pend, 0);

        // Snapshot and dump start on the same edge stream the new snapshot.
        write_live(8'hFF, {8{8'h5A}});
        snap = 1'b1; dump_start = 1'b1;
        step();
        snap = 1'b0; dump_start = 1'b0;
        snaps++;
        check("sd_valid", st_valid, 1);
        check("sd_data", st_data, 8'h5A);
        check("sd_cnt", snap_cnt, exp_cnt());
        st_ready = 1'b1;
        beats = 0;
        for (int c = 0; c < 20 && dump_busy; c++) begin
            step();
            beats++;
        end
        st_ready = 1'b0;
        check("sd_beats", beats, 8);
        check("sd_busy_end", dump_busy, 0);

        // Counter wrap (enabled build) or tie-off (default build).
        do_reset();
        snap = 1'b1;
        if (CNT_EN) begin
            for (int k = 0; k < 65535; k++) step();
            check("wrap_ffff", snap_cnt, 16'hFFFF);
            step();
            check("wrap_zero", snap_cnt, 16'h0000);
        end else begin
            for (int k = 0; k < 5; k++) step();
            check("cnt_tied", snap_cnt, 16'h0000);
        end
        snap = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
